// File: rtl/flt_pkg.sv
// Shared IEEE-754 single-precision constants and the input classification
// used by the float-to-fixed pipeline.
package flt_pkg;
    localparam int FLT_EXP_BIAS = 127;
    localparam int FLT_MANT_W   = 23;
    localparam int FLT_EXP_W    = 8;
    localparam int FLT_EXP_MAX  = 255;

    typedef enum logic [1:0] {ZERO, NORM, INF, NAN} flt_cls_t;

    function automatic flt_cls_t flt_classify(input logic [FLT_EXP_W-1:0]  exp_f,
                                              input logic [FLT_MANT_W-1:0] mant_f);
        if (exp_f == '0)
            return ZERO;
        if (exp_f == FLT_EXP_W'(FLT_EXP_MAX))
            return (mant_f != '0) ? NAN : INF;
        return NORM;
    endfunction
endpackage

// File: rtl/flt2fix_pipe_if.sv
// Valid/ready stream bundle: float beats in, fixed-point result plus flags out.
interface flt2fix_pipe_if #(
    parameter int OUT_W = 13
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      flt_in;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;
    logic             out_nan;

    modport master (
        output in_valid, flt_in, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_nan
    );

    modport slave (
        input  in_valid, flt_in, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_nan
    );
endinterface

// File: rtl/flt2fix_round_sat.sv
// Rounds an aligned magnitude (half away from zero or truncate), applies the sign
// and clamps to the signed OUT_W range, flagging any clamp.
module flt2fix_round_sat #(
    parameter int OUT_W    = 13,
    parameter int MAG_W    = 24,
    parameter bit RND_NEAR = 1'b1
) (
    input  logic [MAG_W-1:0] mag,
    input  logic             guard,
    input  logic             sticky,
    input  logic             sign,
    input  logic             ovf,
    output logic [OUT_W-1:0] data,
    output logic             sat
);
    localparam int POS_LIM = (1 << (OUT_W - 1)) - 1;
    localparam int NEG_LIM = 1 << (OUT_W - 1);
    localparam logic [OUT_W-1:0] MAX_CODE = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_CODE = {1'b1, {(OUT_W-1){1'b0}}};

    logic [MAG_W:0] mag_r;
    logic [MAG_W:0] neg_r;
    logic           sticky_unused;

    // Half-away-from-zero only looks at the guard bit; sticky is carried for half-even.
    assign sticky_unused = sticky;

    always_comb begin
        mag_r = {1'b0, mag} + (MAG_W+1)'(RND_NEAR && guard);
        neg_r = -mag_r;
        sat   = 1'b0;
        data  = sign ? neg_r[OUT_W-1:0] : mag_r[OUT_W-1:0];
        if (ovf || (!sign && (mag_r > (MAG_W+1)'(POS_LIM)))
                || ( sign && (mag_r > (MAG_W+1)'(NEG_LIM)))) begin
            sat  = 1'b1;
            data = sign ? MIN_CODE : MAX_CODE;
        end
    end
endmodule

// File: rtl/flt2fix_pipe.sv
// Three-stage IEEE-754 single to signed fixed-point converter with valid/ready
// flow control and a sticky saturation-event counter.
module flt2fix_pipe
    import flt_pkg::*;
#(
    parameter int INT_W    = 4,
    parameter int FRAC_W   = 8,
    parameter bit RND_NEAR = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    flt2fix_pipe_if.slave    io,
    input  logic             sat_clr,
    output logic [CNT_W-1:0] sat_count
);
    localparam int OUT_W   = 1 + INT_W + FRAC_W;
    localparam int MANT_F  = FLT_MANT_W + 1;
    localparam int RS_BASE = FLT_EXP_BIAS + FLT_MANT_W - FRAC_W;

    logic v1, v2, v3, ld1, ld2, ld3;

    logic                 s1_sign;
    logic [FLT_EXP_W-1:0] s1_exp;
    logic [MANT_F-1:0]    s1_mant;
    flt_cls_t             s1_cls;

    logic                 s2_sign, s2_guard, s2_sticky, s2_ovf, s2_nan;
    logic [MANT_F-1:0]    s2_mag;

    logic [MANT_F-1:0]    mag_d;
    logic                 guard_d, sticky_d, ovf_d;
    logic signed [10:0]   rs;
    logic [2*MANT_F-1:0]  wide;

    logic [OUT_W-1:0]     rs_data, d3;
    logic                 rs_sat, sat3, nan3;

    // A stage advances when it is empty or its successor is advancing.
    assign ld3 = !v3 || io.out_ready;
    assign ld2 = !v2 || ld3;
    assign ld1 = !v1 || ld2;

    assign io.in_ready  = ld1;
    assign io.out_valid = v3;
    assign io.out_data  = d3;
    assign io.out_sat   = sat3;
    assign io.out_nan   = nan3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            s1_sign <= 1'b0;
            s1_exp  <= '0;
            s1_mant <= '0;
            s1_cls  <= ZERO;
        end else if (ld1) begin
            v1 <= io.in_valid;
            if (io.in_valid) begin
                s1_sign <= io.flt_in[31];
                s1_exp  <= io.flt_in[FLT_MANT_W +: FLT_EXP_W];
                s1_mant <= {1'b1, io.flt_in[FLT_MANT_W-1:0]};
                s1_cls  <= flt_classify(io.flt_in[FLT_MANT_W +: FLT_EXP_W],
                                        io.flt_in[FLT_MANT_W-1:0]);
            end
        end
    end

    // Right-shift distance; a non-positive distance always exceeds the output range.
    always_comb begin
        mag_d    = '0;
        guard_d  = 1'b0;
        sticky_d = 1'b0;
        ovf_d    = 1'b0;
        rs       = 11'(RS_BASE) - 11'(s1_exp);
        wide     = {s1_mant, {MANT_F{1'b0}}} >> rs[5:0];
        unique case (s1_cls)
            INF: ovf_d = 1'b1;
            NORM: begin
                if (int'(rs) <= 0) begin
                    ovf_d = 1'b1;
                end else if (int'(rs) > MANT_F) begin
                    sticky_d = 1'b1;
                end else begin
                    mag_d    = wide[2*MANT_F-1 -: MANT_F];
                    guard_d  = wide[MANT_F-1];
                    sticky_d = |wide[MANT_F-2:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2        <= 1'b0;
            s2_sign   <= 1'b0;
            s2_mag    <= '0;
            s2_guard  <= 1'b0;
            s2_sticky <= 1'b0;
            s2_ovf    <= 1'b0;
            s2_nan    <= 1'b0;
        end else if (ld2) begin
            v2 <= v1;
            if (v1) begin
                s2_sign   <= s1_sign;
                s2_mag    <= mag_d;
                s2_guard  <= guard_d;
                s2_sticky <= sticky_d;
                s2_ovf    <= ovf_d;
                s2_nan    <= (s1_cls == NAN);
            end
        end
    end

    flt2fix_round_sat #(
        .OUT_W    (OUT_W),
        .MAG_W    (MANT_F),
        .RND_NEAR (RND_NEAR)
    ) u_round_sat (
        .mag    (s2_mag),
        .guard  (s2_guard),
        .sticky (s2_sticky),
        .sign   (s2_sign),
        .ovf    (s2_ovf),
        .data   (rs_data),
        .sat    (rs_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3   <= 1'b0;
            d3   <= '0;
            sat3 <= 1'b0;
            nan3 <= 1'b0;
        end else if (ld3) begin
            v3 <= v2;
            if (v2) begin
                d3   <= rs_data;
                sat3 <= rs_sat;
                nan3 <= s2_nan;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_count <= '0;
        else if (sat_clr)
            sat_count <= '0;
        else if (v3 && io.out_ready && sat3 && !(&sat_count))
            sat_count <= sat_count + 1'b1;
    end
endmodule

// File: tb/tb_flt2fix_pipe.sv
// Bench for flt2fix_pipe: directed corner values, back-pressure, reset and a
// randomized stream scored against a real-arithmetic reference model.
module tb_flt2fix_pipe;
    localparam int FRAC_W  = 8;
    localparam int OUT_W   = 13;
    localparam int POS_LIM = 4095;
    localparam int NEG_LIM = 4096;
    localparam int CNT_MAX = 65535;

    logic        clk;
    logic        rst;
    logic        sat_clr_n, sat_clr_t;
    logic [15:0] sat_count_n, sat_count_t;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    int mcnt;

    flt2fix_pipe_if #(.OUT_W(OUT_W)) io_n ();
    flt2fix_pipe_if #(.OUT_W(OUT_W)) io_t ();

    flt2fix_pipe #(.INT_W(4), .FRAC_W(FRAC_W), .RND_NEAR(1'b1), .CNT_W(16)) dut_n (
        .clk(clk), .rst(rst), .io(io_n), .sat_clr(sat_clr_n), .sat_count(sat_count_n));

    flt2fix_pipe #(.INT_W(4), .FRAC_W(FRAC_W), .RND_NEAR(1'b0), .CNT_W(16)) dut_t (
        .clk(clk), .rst(rst), .io(io_t), .sat_clr(sat_clr_t), .sat_count(sat_count_t));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    // Exact value of the float scaled by 2^FRAC_W, then rounded and clamped.
    function automatic void ref_conv(input logic [31:0] f, input bit near,
                                     output int d, output bit s, output bit n);
        int  e;
        real mag, r;
        e = int'(f[30:23]);
        d = 0; s = 1'b0; n = 1'b0;
        if (e == 255) begin
            if (f[22:0] != 23'd0) n = 1'b1;
            else begin
                s = 1'b1;
                d = f[31] ? -NEG_LIM : POS_LIM;
            end
        end else if (e != 0) begin
            mag = real'({1'b1, f[22:0]}) * (2.0 ** real'(e - 150 + FRAC_W));
            r   = near ? $floor(mag + 0.5) : $floor(mag);
            if (f[31]) begin
                if (r > real'(NEG_LIM)) begin s = 1'b1; d = -NEG_LIM; end
                else d = -int'(r);
            end else begin
                if (r > real'(POS_LIM)) begin s = 1'b1; d = POS_LIM; end
                else d = int'(r);
            end
        end
    endfunction

    function automatic logic [31:0] rand_flt();
        int         sel;
        logic [7:0] e;
        logic [22:0] m;
        sel = $urandom_range(0, 15);
        m   = 23'($urandom);
        if (sel == 0)      e = 8'd0;
        else if (sel == 1) begin e = 8'd255; if ($urandom_range(0, 1) == 0) m = '0; end
        else if (sel == 2) e = 8'($urandom_range(0, 255));
        else               e = 8'($urandom_range(110, 136));
        if (sel == 3) m = '0;
        return {1'($urandom_range(0, 1)), e, m};
    endfunction

    // Scoreboard / protocol monitor for the round-to-nearest instance.
    initial begin : monitor
        int   d;
        bit   s, n, beat, hold_pend;
        logic [31:0] f;
        int   hold_d, hold_f;
        mcnt = 0;
        hold_pend = 1'b0;
        hold_d = 0;
        hold_f = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                mcnt = 0;
                hold_pend = 1'b0;
            end else begin
                chk("sat_count", int'(sat_count_n), mcnt);
                if (hold_pend) begin
                    chk("hold_data", int'($signed(io_n.out_data)), hold_d);
                    chk("hold_flags", int'({io_n.out_sat, io_n.out_nan}), hold_f);
                    chk("hold_valid", int'(io_n.out_valid), 1);
                end
                hold_pend = io_n.out_valid && !io_n.out_ready;
                hold_d    = int'($signed(io_n.out_data));
                hold_f    = int'({io_n.out_sat, io_n.out_nan});
                beat = io_n.out_valid && io_n.out_ready;
                if (beat) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", int'(io_n.out_valid), 0);
                    end else begin
                        f = exp_q.pop_front();
                        ref_conv(f, 1'b1, d, s, n);
                        chk($sformatf("data_%08h", f), int'($signed(io_n.out_data)), d);
                        chk($sformatf("sat_%08h", f), int'(io_n.out_sat), int'(s));
                        chk($sformatf("nan_%08h", f), int'(io_n.out_nan), int'(n));
                    end
                end
                if (sat_clr_n) mcnt = 0;
                else if (beat && io_n.out_sat && mcnt != CNT_MAX) mcnt++;
                if (io_n.in_valid && io_n.in_ready) exp_q.push_back(io_n.flt_in);
            end
        end
    end

    task automatic send(input logic [31:0] f);
        io_n.in_valid = 1'b1;
        io_n.flt_in   = f;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (io_n.in_ready) begin
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        chk("send_timeout", int'(io_n.in_ready), 1);
    endtask

    task automatic run_one(input string tag, input logic [31:0] f,
                           input int d, input int s, input int n);
        int lat;
        io_n.out_ready = 1'b1;
        send(f);
        io_n.in_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (io_n.out_valid) break;
        end
        chk({tag, "_lat"}, lat, 3);
        chk({tag, "_data"}, int'($signed(io_n.out_data)), d);
        chk({tag, "_sat"}, int'(io_n.out_sat), s);
        chk({tag, "_nan"}, int'(io_n.out_nan), n);
        @(posedge clk); #1;
    endtask

    task automatic run_t(input string tag, input logic [31:0] f, input int d);
        io_t.in_valid = 1'b1;
        io_t.flt_in   = f;
        @(negedge clk);
        chk({tag, "_rdy"}, int'(io_t.in_ready), 1);
        @(posedge clk); #1;
        io_t.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (io_t.out_valid) break;
        end
        chk({tag, "_valid"}, int'(io_t.out_valid), 1);
        chk({tag, "_data"}, int'($signed(io_t.out_data)), d);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic wait_out_valid(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (io_n.out_valid) break;
            @(posedge clk); #1;
        end
        chk(tag, int'(io_n.out_valid), 1);
    endtask

    initial begin : stim
        logic [31:0] beats [6];
        logic [31:0] f;
        int k, n_acc, d;
        bit acc, s, n;

        rst = 1'b1;
        sat_clr_n = 1'b0; sat_clr_t = 1'b0;
        io_n.in_valid = 1'b0; io_n.flt_in = '0; io_n.out_ready = 1'b1;
        io_t.in_valid = 1'b0; io_t.flt_in = '0; io_t.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(io_n.out_valid), 0);
        chk("rst_out_data", int'(io_n.out_data), 0);
        chk("rst_flags", int'({io_n.out_sat, io_n.out_nan}), 0);
        chk("rst_sat_count", int'(sat_count_n), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(io_n.in_ready), 1);
        @(posedge clk); #1;

        run_one("p1_5", 32'h3FC00000, 384, 0, 0);
        run_one("m2_75", 32'hC0300000, -704, 0, 0);
        run_one("p100", 32'h42C80000, 4095, 1, 0);
        run_one("ninf", 32'hFF800000, -4096, 1, 0);
        chk("sat_count_2", int'(sat_count_n), 2);
        run_one("m16", 32'hC1800000, -4096, 0, 0);
        run_one("p16", 32'h41800000, 4095, 1, 0);
        run_one("rnd_carry", 32'h417FFFFF, 4095, 1, 0);
        run_one("half_lsb", 32'h3B000000, 1, 0, 0);
        run_one("below_half", 32'h3AFFFFFF, 0, 0, 0);
        run_one("denorm", 32'h00000001, 0, 0, 0);
        run_one("mzero", 32'h80000000, 0, 0, 0);
        run_one("nan", 32'h7FC00000, 0, 0, 1);

        run_t("t_half", 32'h3B000000, 0);
        run_t("t_one_lsb", 32'h3B800000, 1);
        run_t("t_p1_5", 32'h3FC00000, 384);
        run_t("t_m2_75", 32'hC0300000, -704);
        run_t("t_rnd_carry", 32'h417FFFFF, 4095);
        for (int i = 0; i < 20; i++) begin
            f = rand_flt();
            ref_conv(f, 1'b0, d, s, n);
            run_t($sformatf("t_rand_%08h", f), f, d);
        end

        // Back-pressure: six back-to-back beats against a stalled sink.
        for (int i = 0; i < 6; i++) beats[i] = 32'h3F800000 + (i << 20);
        io_n.out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            io_n.in_valid = 1'b1;
            io_n.flt_in   = beats[k];
            @(negedge clk);
            acc = io_n.in_ready;
            @(posedge clk); #1;
            if (acc) k++;
        end
        chk("bp_accepted", k, 3);
        @(negedge clk);
        chk("bp_in_ready", int'(io_n.in_ready), 0);
        @(posedge clk); #1;
        io_n.out_ready = 1'b1;
        while (k < 6) begin
            send(beats[k]);
            k++;
        end
        io_n.in_valid = 1'b0;
        drain();

        // Randomized stream with random sink stalls.
        n_acc = 0;
        io_n.in_valid = 1'b0;
        for (int c = 0; c < 4000 && n_acc < 300; c++) begin
            if (!io_n.in_valid && $urandom_range(0, 3) != 0) begin
                io_n.in_valid = 1'b1;
                io_n.flt_in   = rand_flt();
            end
            io_n.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = io_n.in_valid && io_n.in_ready;
            @(posedge clk); #1;
            if (acc) begin
                n_acc++;
                io_n.in_valid = 1'b0;
            end
        end
        chk("rand_accepted", n_acc, 300);
        io_n.in_valid  = 1'b0;
        io_n.out_ready = 1'b1;
        drain();

        // sat_clr coinciding with a saturated delivery wins.
        io_n.out_ready = 1'b0;
        send(32'h42C80000);
        io_n.in_valid = 1'b0;
        wait_out_valid("clr_out_valid");
        io_n.out_ready = 1'b1;
        sat_clr_n = 1'b1;
        @(posedge clk); #1;
        sat_clr_n = 1'b0;
        @(negedge clk);
        chk("sat_clr_wins", int'(sat_count_n), 0);
        @(posedge clk); #1;

        // Reset with beats in flight.
        run_one("p100b", 32'h42C80000, 4095, 1, 0);
        chk("pre_rst_cnt", int'(sat_count_n), 1);
        io_n.out_ready = 1'b0;
        send(32'hC2C80000);
        send(32'h3FC00000);
        io_n.in_valid = 1'b0;
        wait_out_valid("pre_rst_valid");
        rst = 1'b1;
        #1;
        chk("rst_kills_valid", int'(io_n.out_valid), 0);
        chk("rst_kills_cnt", int'(sat_count_n), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        io_n.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_valid", int'(io_n.out_valid), 0);
        end
        @(posedge clk); #1;
        run_one("post_rst", 32'hC0300000, -704, 0, 0);
        chk("end_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
